// File: rtl/mega_mul_seq_pkg.sv
// Shared encodings for the MEGA/XMEGA iterative multiplier: op codes, flag indices, FSM states
// and the op decoder that tells the datapath which operands are signed and whether to shift.
package mega_mul_seq_pkg;

  localparam logic [2:0] MEGA_MUL_OP_MUL    = 3'd0;
  localparam logic [2:0] MEGA_MUL_OP_MULS   = 3'd1;
  localparam logic [2:0] MEGA_MUL_OP_MULSU  = 3'd2;
  localparam logic [2:0] MEGA_MUL_OP_FMUL   = 3'd3;
  localparam logic [2:0] MEGA_MUL_OP_FMULS  = 3'd4;
  localparam logic [2:0] MEGA_MUL_OP_FMULSU = 3'd5;

  localparam int XMEGA_FLAG_C = 0;
  localparam int XMEGA_FLAG_Z = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic rd_signed;
    logic rr_signed;
    logic frac;
  } mul_dec_t;

  // Encodings 6 and 7 fall through to plain unsigned MUL.
  function automatic mul_dec_t decode_op(input logic [2:0] op);
    mul_dec_t d;
    d = '0;
    case (op)
      MEGA_MUL_OP_MULS:   begin d.rd_signed = 1'b1; d.rr_signed = 1'b1; end
      MEGA_MUL_OP_MULSU:  begin d.rd_signed = 1'b1; end
      MEGA_MUL_OP_FMUL:   begin d.frac = 1'b1; end
      MEGA_MUL_OP_FMULS:  begin d.rd_signed = 1'b1; d.rr_signed = 1'b1; d.frac = 1'b1; end
      MEGA_MUL_OP_FMULSU: begin d.rd_signed = 1'b1; d.frac = 1'b1; end
      default:            d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mega_mul_seq_step.sv
// One shift-add iteration: folds BITS_PER_CYCLE multiplier bits into the accumulator.
// The caller pre-shifts mcand so bit i of the slice always weighs mcand << i.
module mega_mul_step #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [2*WIDTH-1:0]        acc_in,
  input  logic [2*WIDTH-1:0]        mcand,
  input  logic [BITS_PER_CYCLE-1:0] mplier_slice,
  output logic [2*WIDTH-1:0]        acc_out
);

  always_comb begin
    acc_out = acc_in;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_slice[i]) acc_out = acc_out + (mcand << i);
    end
  end

endmodule

// File: rtl/mega_mul_seq.sv
// Iterative MUL/MULS/MULSU/FMUL/FMULS/FMULSU unit: sign-magnitude shift-add over WIDTH/BITS_PER_CYCLE
// iterations, final negate and flag generation on the edge into DONE.
//
//   state   | meaning
//   IDLE    | waiting for start
//   RUN     | iterating; busy high, cnt counts remaining iterations down to 1
//   DONE    | done pulse; R/sreg_out fresh; may accept a new start
module mega_mul_seq
  import mega_mul_seq_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 flush,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     rd,
  input  logic [WIDTH-1:0]     rr,
  input  logic [7:0]           sreg_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   R,
  output logic [7:0]           sreg_out
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);
  localparam int PW    = 2 * WIDTH;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    acc, acc_nxt, mcand;
  logic [WIDTH-1:0] mplier;
  logic             neg, frac;
  logic [7:0]       sreg_lat;

  mul_dec_t         dec;
  logic [WIDTH-1:0] rd_mag, rr_mag;
  logic             rd_neg, rr_neg;
  logic             accept, last;
  logic [PW-1:0]    p_final, r_final;

  assign dec    = decode_op(op);
  assign rd_neg = dec.rd_signed & rd[WIDTH-1];
  assign rr_neg = dec.rr_signed & rr[WIDTH-1];
  assign rd_mag = rd_neg ? -rd : rd;
  assign rr_mag = rr_neg ? -rr : rr;

  // flush beats start in every state, so a simultaneous issue is simply dropped.
  assign accept = start && !flush && (state != ST_RUN);
  assign last   = (cnt == CNT_W'(1));

  mega_mul_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc_in       (acc),
    .mcand        (mcand),
    .mplier_slice (mplier[BITS_PER_CYCLE-1:0]),
    .acc_out      (acc_nxt)
  );

  assign p_final = neg  ? -acc_nxt : acc_nxt;
  assign r_final = frac ? {p_final[PW-2:0], 1'b0} : p_final;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      neg      <= 1'b0;
      frac     <= 1'b0;
      sreg_lat <= '0;
      R        <= '0;
      sreg_out <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            acc    <= acc_nxt;
            mcand  <= mcand << BITS_PER_CYCLE;
            mplier <= mplier >> BITS_PER_CYCLE;
            cnt    <= cnt - CNT_W'(1);
            if (last) begin
              state                  <= ST_DONE;
              R                      <= r_final;
              sreg_out               <= sreg_lat;
              sreg_out[XMEGA_FLAG_C] <= p_final[PW-1];
              sreg_out[XMEGA_FLAG_Z] <= (r_final == '0);
            end
          end
        end
        default: begin
          if (accept) begin
            state    <= ST_RUN;
            cnt      <= CNT_W'(N);
            acc      <= '0;
            mcand    <= {{WIDTH{1'b0}}, rd_mag};
            mplier   <= rr_mag;
            neg      <= rd_neg ^ rr_neg;
            frac     <= dec.frac;
            sreg_lat <= sreg_in;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mega_mul_seq.sv
// Bench for mega_mul_seq: W=8 at four radices plus a W=16 instance, directed table, corner
// sequences (ignored start, flush, reset, back-to-back) and random ops against a signed model.
module tb_mega_mul_seq;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [7:0]  rd, rr, sreg_in;
  logic [15:0] rd16, rr16;

  logic [3:0]  busy_v, done_v;
  logic [15:0] r_v [4];
  logic [7:0]  s_v [4];
  logic        busy16, done16;
  logic [31:0] r16;
  logic [7:0]  s16;

  int errors = 0;
  int checks = 0;
  int lat_v [4];
  int lat16;
  logic busy_c1;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_bpc
    mega_mul_seq #(.WIDTH(8), .BITS_PER_CYCLE(1 << g)) u_dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
      .rd(rd), .rr(rr), .sreg_in(sreg_in),
      .busy(busy_v[g]), .done(done_v[g]), .R(r_v[g]), .sreg_out(s_v[g])
    );
  end

  mega_mul_seq #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_w16 (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .rd(rd16), .rr(rr16), .sreg_in(sreg_in),
    .busy(busy16), .done(done16), .R(r16), .sreg_out(s16)
  );

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  rd;
    logic [7:0]  rr;
    logic [7:0]  sreg;
    logic [15:0] exp_r;
    logic        exp_c;
    logic        exp_z;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: plain signed/unsigned multiply, returns {C, R}.
  function automatic logic [32:0] model(input int w, input logic [2:0] o,
                                        input logic [15:0] a, input logic [15:0] b);
    logic sa_s, sb_s, fr;
    longint sa, sb, p, mask;
    logic [31:0] pm, r;
    sa_s = (o == 3'd1) || (o == 3'd2) || (o == 3'd4) || (o == 3'd5);
    sb_s = (o == 3'd1) || (o == 3'd4);
    fr   = (o >= 3'd3) && (o <= 3'd5);
    sa = longint'(a);
    sb = longint'(b);
    if (sa_s && a[w-1]) sa = sa - (longint'(1) << w);
    if (sb_s && b[w-1]) sb = sb - (longint'(1) << w);
    p    = sa * sb;
    mask = (longint'(1) << (2 * w)) - 1;
    pm   = 32'(p & mask);
    r    = fr ? 32'((p << 1) & mask) : pm;
    return {pm[2*w-1], r};
  endfunction

  // Issue one op from the current cycle and wait for the BPC=1 instance's done.
  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] a16, input logic [15:0] b16, input logic [7:0] s);
    int cyc;
    op = o; rd = a; rr = b; rd16 = a16; rr16 = b16; sreg_in = s; start = 1'b1;
    tick();
    start = 1'b0;
    busy_c1 = busy_v[0];
    for (int g = 0; g < 4; g++) lat_v[g] = 0;
    lat16 = 0;
    cyc = 1;
    while (1) begin
      for (int g = 0; g < 4; g++) if (done_v[g] && lat_v[g] == 0) lat_v[g] = cyc;
      if (done16 && lat16 == 0) lat16 = cyc;
      if (done_v[0] || cyc >= 40) break;
      tick();
      cyc++;
    end
    if (!done_v[0]) chk("done_timeout", 32'(done_v[0]), 32'd1);
  endtask

  initial begin
    logic [32:0] e, e16;
    logic [7:0]  es;
    logic        saw_done;
    int          cyc;

    vecs[0]  = '{3'd0, 8'hFF, 8'hFF, 8'h00, 16'hFE01, 1'b1, 1'b0};
    vecs[1]  = '{3'd1, 8'h80, 8'h80, 8'h00, 16'h4000, 1'b0, 1'b0};
    vecs[2]  = '{3'd2, 8'hFF, 8'hFF, 8'hFF, 16'hFF01, 1'b1, 1'b0};
    vecs[3]  = '{3'd3, 8'h80, 8'h80, 8'h00, 16'h8000, 1'b0, 1'b0};
    vecs[4]  = '{3'd5, 8'h80, 8'h80, 8'h00, 16'h8000, 1'b1, 1'b0};
    vecs[5]  = '{3'd0, 8'h00, 8'h37, 8'hA5, 16'h0000, 1'b0, 1'b1};
    vecs[6]  = '{3'd1, 8'hFF, 8'hFF, 8'h5A, 16'h0001, 1'b0, 1'b0};
    vecs[7]  = '{3'd4, 8'h80, 8'h80, 8'h00, 16'h8000, 1'b0, 1'b0};
    vecs[8]  = '{3'd7, 8'h10, 8'h10, 8'h00, 16'h0100, 1'b0, 1'b0};
    vecs[9]  = '{3'd3, 8'h40, 8'h40, 8'h00, 16'h2000, 1'b0, 1'b0};
    vecs[10] = '{3'd5, 8'hFF, 8'h01, 8'h00, 16'hFFFE, 1'b1, 1'b0};
    vecs[11] = '{3'd2, 8'h7F, 8'hFF, 8'h3C, 16'h7E81, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0;
    rd = '0; rr = '0; rd16 = '0; rr16 = '0; sreg_in = '0;
    repeat (3) tick();
    chk("reset_busy", 32'(busy_v), 32'd0);
    chk("reset_done", 32'(done_v), 32'd0);
    chk("reset_r", 32'(r_v[0]), 32'd0);
    chk("reset_sreg", 32'(s_v[0]), 32'd0);
    chk("reset_r16", r16, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].rd, vecs[i].rr, 16'h0, 16'h0, vecs[i].sreg);
      es = {vecs[i].sreg[7:2], vecs[i].exp_z, vecs[i].exp_c};
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("vec%0d_r_bpc%0d", i, 1 << g), 32'(r_v[g]), 32'(vecs[i].exp_r));
        chk($sformatf("vec%0d_sreg_bpc%0d", i, 1 << g), 32'(s_v[g]), 32'(es));
        chk($sformatf("vec%0d_lat_bpc%0d", i, 1 << g), 32'(lat_v[g]), 32'((8 >> g) + 1));
      end
      tick();
      chk($sformatf("vec%0d_done_pulse", i), 32'(done_v[0]), 32'd0);
    end

    // start during RUN must be ignored
    run_op(3'd0, 8'h03, 8'h05, 16'h0, 16'h0, 8'h00);
    chk("seed_r", 32'(r_v[0]), 32'h000F);
    tick();
    op = 3'd0; rd = 8'h02; rr = 8'h02; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done_v[0] && cyc < 40) begin
      if (cyc == 3) begin start = 1'b1; rd = 8'hFF; rr = 8'hFF; end
      else start = 1'b0;
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("ignored_start_lat", 32'(cyc), 32'd9);
    chk("ignored_start_r", 32'(r_v[0]), 32'h0004);
    tick();

    // flush plus start at cycle 4: killed, start dropped, R holds
    op = 3'd0; rd = 8'h09; rr = 8'h09; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    flush = 1'b1; start = 1'b1; rd = 8'hFF; rr = 8'hFF;
    tick();
    flush = 1'b0; start = 1'b0;
    chk("flush_busy", 32'(busy_v[0]), 32'd0);
    saw_done = 1'b0;
    repeat (12) begin
      saw_done = saw_done | done_v[0];
      tick();
    end
    chk("flush_no_done", 32'(saw_done), 32'd0);
    chk("flush_r_hold", 32'(r_v[0]), 32'h0004);

    // reset mid-run at cycle 5
    op = 3'd0; rd = 8'h03; rr = 8'h03; sreg_in = 8'hF0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy", 32'(busy_v[0]), 32'd0);
    chk("midrst_done", 32'(done_v[0]), 32'd0);
    chk("midrst_r", 32'(r_v[0]), 32'd0);
    chk("midrst_sreg", 32'(s_v[0]), 32'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      tick();
      saw_done = saw_done | done_v[0];
    end
    chk("midrst_no_done", 32'(saw_done), 32'd0);

    // back-to-back: start in the DONE cycle
    run_op(3'd0, 8'h03, 8'h03, 16'h0, 16'h0, 8'h00);
    chk("b2b_first_r", 32'(r_v[0]), 32'h0009);
    run_op(3'd0, 8'h04, 8'h04, 16'h0, 16'h0, 8'h00);
    chk("b2b_busy_c1", 32'(busy_c1), 32'd1);
    chk("b2b_gap", 32'(lat_v[0]), 32'd9);
    chk("b2b_second_r", 32'(r_v[0]), 32'h0010);
    tick();

    // random ops, all radices and W=16 against the reference multiply
    for (int k = 0; k < 200; k++) begin
      logic [2:0]  o;
      logic [7:0]  a, b, s;
      logic [15:0] a16, b16;
      o = 3'($urandom_range(0, 7));
      a = 8'($urandom); b = 8'($urandom); s = 8'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom);
      if (k < 6) begin a = 8'h80; b = 8'h80; a16 = 16'h8000; b16 = 16'h8000; o = 3'(k); end
      e   = model(8, o, {8'h00, a}, {8'h00, b});
      e16 = model(16, o, a16, b16);
      run_op(o, a, b, a16, b16, s);
      for (int g = 0; g < 4; g++)
        chk($sformatf("rnd%0d_r_bpc%0d op%0d %0h*%0h", k, 1 << g, o, a, b),
            32'(r_v[g]), 32'(e[15:0]));
      chk($sformatf("rnd%0d_sreg", k), 32'(s_v[0]), 32'({s[7:2], e[15:0] == 16'h0, e[32]}));
      chk($sformatf("rnd%0d_r16 op%0d %0h*%0h", k, o, a16, b16), r16, e16[31:0]);
      chk($sformatf("rnd%0d_sreg16", k), 32'(s16), 32'({s[7:2], e16[31:0] == 32'h0, e16[32]}));
      if (k == 0) chk("w16_lat", 32'(lat16), 32'd5);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
